// File: rtl/xm_mem_ctrl.sv
// ============================================================================
//  Module   : xm_mem_ctrl
//  Brief    : Single-outstanding memory-access controller: bridges a level
//             request from the control plane onto a Wishbone-style bus.
//             Optional macro XM_MEM_TIMEOUT_EN adds a REQ-state watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module xm_mem_ctrl #(
    parameter int WORD    = 16,
    parameter int TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            memEn_i,
    input  logic            memWr_i,
    input  logic            byteOp_i,
    input  logic [WORD-1:0] adr_i,
    input  logic [WORD-1:0] wdat_i,
    output logic [WORD-1:0] rdat_o,
    output logic            memBusy_o,
    output logic            memDone_o,
    output logic            badMem_o,
    input  logic            ack_i,
    input  logic [WORD-1:0] dat_i,
    output logic            we_o,
    output logic            stb_o,
    output logic            cyc_o,
    output logic [1:0]      sel_o,
    output logic [WORD-1:0] adr_o,
    output logic [WORD-1:0] dat_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte lanes assume a datapath of at least two bytes.
    if (WORD < 16 || TIMEOUT < 1) begin : g_paramCheck
        $error("xm_mem_ctrl: WORD must be >= 16 and TIMEOUT >= 1");
    end

    state_t          r_state, w_stateNext;
    logic            r_cyc, w_cycNext;
    logic            r_we, w_weNext;
    logic [1:0]      r_sel, w_selNext;
    logic [WORD-1:0] r_adr, w_adrNext;
    logic [WORD-1:0] r_dat, w_datNext;
    logic [WORD-1:0] r_rdat, w_rdatNext;
    logic            r_wr, w_wrNext;
    logic            r_byte, w_byteNext;
    logic            r_busy, w_busyNext;
    logic            r_done, w_doneNext;
    logic            r_bad, w_badNext;

`ifdef XM_MEM_TIMEOUT_EN
    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    logic [c_CNT_W-1:0] r_cnt, w_cntNext;
`endif

    logic [WORD-1:0] w_byteWdat;
    logic [WORD-1:0] w_byteRdat;

    // Byte writes replicate the low byte onto both lanes; byte reads pick the
    // lane addressed by the latched address LSB and zero-extend it.
    always_comb begin
        w_byteWdat        = '0;
        w_byteWdat[15:0]  = {wdat_i[7:0], wdat_i[7:0]};
        w_byteRdat        = '0;
        w_byteRdat[7:0]   = r_adr[0] ? dat_i[15:8] : dat_i[7:0];
    end

    always_comb begin
        w_stateNext = r_state;
        w_cycNext   = r_cyc;
        w_weNext    = r_we;
        w_selNext   = r_sel;
        w_adrNext   = r_adr;
        w_datNext   = r_dat;
        w_rdatNext  = r_rdat;
        w_wrNext    = r_wr;
        w_byteNext  = r_byte;
        w_busyNext  = 1'b0;
        w_doneNext  = 1'b0;
        w_badNext   = 1'b0;
`ifdef XM_MEM_TIMEOUT_EN
        w_cntNext   = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (memEn_i) begin
                    w_adrNext  = adr_i;
                    w_wrNext   = memWr_i;
                    w_byteNext = byteOp_i;
                    w_datNext  = byteOp_i ? w_byteWdat : wdat_i;
                    if (!byteOp_i && adr_i[0]) begin
                        // Misaligned word: report an error without a bus cycle.
                        w_stateNext = DONE;
                        w_doneNext  = 1'b1;
                        w_badNext   = 1'b1;
                    end else begin
                        w_stateNext = REQ;
                        w_cycNext   = 1'b1;
                        w_weNext    = memWr_i;
                        w_selNext   = !byteOp_i ? 2'b11 : (adr_i[0] ? 2'b10 : 2'b01);
                        w_busyNext  = 1'b1;
`ifdef XM_MEM_TIMEOUT_EN
                        w_cntNext   = '0;
`endif
                    end
                end
            end
            REQ: begin
                if (ack_i) begin
                    w_stateNext = DONE;
                    w_cycNext   = 1'b0;
                    w_weNext    = 1'b0;
                    w_selNext   = 2'b00;
                    w_doneNext  = 1'b1;
                    if (!r_wr) begin
                        w_rdatNext = r_byte ? w_byteRdat : dat_i;
                    end
                end
`ifdef XM_MEM_TIMEOUT_EN
                else if (r_cnt == c_CNT_LAST) begin
                    // Ack on the terminal cycle takes the branch above instead.
                    w_stateNext = DONE;
                    w_cycNext   = 1'b0;
                    w_weNext    = 1'b0;
                    w_selNext   = 2'b00;
                    w_doneNext  = 1'b1;
                    w_badNext   = 1'b1;
                end else begin
                    w_busyNext  = 1'b1;
                    w_cntNext   = r_cnt + 1'b1;
                end
`else
                else begin
                    w_busyNext  = 1'b1;
                end
`endif
            end
            DONE: begin
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
                w_cycNext   = 1'b0;
                w_weNext    = 1'b0;
                w_selNext   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            r_state <= IDLE;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_sel   <= 2'b00;
            r_adr   <= '0;
            r_dat   <= '0;
            r_rdat  <= '0;
            r_wr    <= 1'b0;
            r_byte  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_bad   <= 1'b0;
`ifdef XM_MEM_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            r_state <= w_stateNext;
            r_cyc   <= w_cycNext;
            r_we    <= w_weNext;
            r_sel   <= w_selNext;
            r_adr   <= w_adrNext;
            r_dat   <= w_datNext;
            r_rdat  <= w_rdatNext;
            r_wr    <= w_wrNext;
            r_byte  <= w_byteNext;
            r_busy  <= w_busyNext;
            r_done  <= w_doneNext;
            r_bad   <= w_badNext;
`ifdef XM_MEM_TIMEOUT_EN
            r_cnt   <= w_cntNext;
`endif
        end
    end

    assign cyc_o     = r_cyc;
    assign stb_o     = r_cyc;
    assign we_o      = r_we;
    assign sel_o     = r_sel;
    assign adr_o     = r_adr;
    assign dat_o     = r_dat;
    assign rdat_o    = r_rdat;
    assign memBusy_o = r_busy;
    assign memDone_o = r_done;
    assign badMem_o  = r_bad;

endmodule

`default_nettype wire

// File: tb/tb_xm_mem_ctrl.sv
// ============================================================================
//  Module   : tb_xm_mem_ctrl
//  Brief    : Self-checking bench for xm_mem_ctrl: transaction-level model,
//             per-cycle output compare, directed literal scenarios, random run.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xm_mem_ctrl;

    localparam int c_TIMEOUT = 15;

    logic        clk, arst, memEn, memWr, byteOp, ack;
    logic [15:0] adr, wdat, dat;
    logic [15:0] rdat_o, adr_o, dat_o;
    logic        memBusy_o, memDone_o, badMem_o, we_o, stb_o, cyc_o;
    logic [1:0]  sel_o;

    xm_mem_ctrl #(.WORD(16), .TIMEOUT(c_TIMEOUT)) dut (
        .clk_i(clk), .arst_i(arst), .memEn_i(memEn), .memWr_i(memWr),
        .byteOp_i(byteOp), .adr_i(adr), .wdat_i(wdat), .rdat_o(rdat_o),
        .memBusy_o(memBusy_o), .memDone_o(memDone_o), .badMem_o(badMem_o),
        .ack_i(ack), .dat_i(dat), .we_o(we_o), .stb_o(stb_o), .cyc_o(cyc_o),
        .sel_o(sel_o), .adr_o(adr_o), .dat_o(dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nVec = 0;
    int nErr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus responder: 0 = random acks/data, 1 = ack one cycle after strobe, 2 = never ack.
    int          respMode = 0;
    logic [15:0] dirDat   = 16'h0000;
    always @(posedge clk) begin
        #1;
        if (respMode == 0) begin
            ack = ($urandom_range(0, 2) == 0);
            dat = 16'($urandom);
        end else if (respMode == 1) begin
            ack = stb_o;
            dat = dirDat;
        end else begin
            ack = 1'b0;
            dat = 16'($urandom);
        end
    end

    // Transaction-level model: one outstanding access, a one-cycle completion slot.
    logic        mBusy = 1'b0, mDone = 1'b0, mBad = 1'b0, mWr = 1'b0, mByte = 1'b0;
    logic [15:0] mAdr = '0, mWdat = '0, mRdat = '0;
    int          mCycles = 0;

    always @(posedge clk) begin
        if (arst) begin
            mBusy <= 1'b0; mDone <= 1'b0; mBad <= 1'b0; mRdat <= '0;
        end else if (mDone) begin
            mDone <= 1'b0; mBad <= 1'b0;
        end else if (mBusy) begin
            if (ack) begin
                mBusy <= 1'b0; mDone <= 1'b1; mBad <= 1'b0;
                if (!mWr)
                    mRdat <= !mByte ? dat : {8'h00, (mAdr[0] ? dat[15:8] : dat[7:0])};
            end
`ifdef XM_MEM_TIMEOUT_EN
            else if (mCycles + 1 == c_TIMEOUT) begin
                mBusy <= 1'b0; mDone <= 1'b1; mBad <= 1'b1;
            end
`endif
            else mCycles <= mCycles + 1;
        end else if (memEn) begin
            mWr <= memWr; mByte <= byteOp; mAdr <= adr; mWdat <= wdat;
            if (!byteOp && adr[0]) begin
                mDone <= 1'b1; mBad <= 1'b1;
            end else begin
                mBusy <= 1'b1; mCycles <= 0;
            end
        end
    end

    function automatic logic [1:0] expSel();
        if (!mBusy) return 2'b00;
        if (!mByte) return 2'b11;
        return mAdr[0] ? 2'b10 : 2'b01;
    endfunction

    bit chkEn = 1'b0;
    always @(negedge clk) begin
        if (chkEn) begin
            chk("cyc", cyc_o, mBusy);
            chk("stb", stb_o, mBusy);
            chk("busy", memBusy_o, mBusy);
            chk("we", we_o, mBusy & mWr);
            chk("sel", sel_o, expSel());
            chk("done", memDone_o, mDone);
            chk("rdat", rdat_o, mRdat);
            if (mDone) chk("bad", badMem_o, mBad);
            if (mBusy) begin
                chk("adr_o", adr_o, mAdr);
                chk("dat_o", dat_o, mByte ? {mWdat[7:0], mWdat[7:0]} : mWdat);
            end
        end
    end

    // Directed access: snapshot outputs one and two cycles after the accept edge.
    logic        sStb, sWe, dDone1, dBad1, dDone2, dBad2, dCyc2;
    logic [1:0]  sSel;
    logic [15:0] sDat, dRdat2;

    task automatic dirTxn(input logic wr, input logic bo, input logic [15:0] a, input logic [15:0] wd);
        memEn = 1'b1; memWr = wr; byteOp = bo; adr = a; wdat = wd;
        @(negedge clk);
        sStb = stb_o; sWe = we_o; sSel = sel_o; sDat = dat_o;
        dDone1 = memDone_o; dBad1 = badMem_o;
        @(negedge clk);
        dDone2 = memDone_o; dBad2 = badMem_o; dRdat2 = rdat_o; dCyc2 = cyc_o;
        memEn = 1'b0;
        @(negedge clk);
    endtask

    task automatic rndTxn();
        bit seen = 1'b0;
        memEn = 1'b1; memWr = 1'($urandom); byteOp = 1'($urandom);
        adr = 16'($urandom); wdat = 16'($urandom);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (memDone_o) begin seen = 1'b1; break; end
        end
        if (!seen) chk("txn_done_bound", 32'd0, 32'd1);
        if ($urandom_range(0, 1) == 1) @(negedge clk);
        memEn = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    initial begin
        int cnt;
        bit gotDone, gotBad;
        arst = 1'b1; memEn = 1'b0; memWr = 1'b0; byteOp = 1'b0;
        adr = '0; wdat = '0; ack = 1'b0; dat = '0;
        repeat (2) @(negedge clk);
        chk("rst_cyc", cyc_o, 0);
        chk("rst_busy", memBusy_o, 0);
        chk("rst_rdat", rdat_o, 0);
        chk("rst_adr", adr_o, 0);
        arst = 1'b0;
        chkEn = 1'b1;
        @(negedge clk);

        // Word read.
        respMode = 1; dirDat = 16'hBEEF;
        dirTxn(1'b0, 1'b0, 16'h0100, 16'h1111);
        chk("wr_stb", sStb, 1); chk("wr_sel", sSel, 2'b11);
        chk("wr_done", dDone2, 1); chk("wr_bad", dBad2, 0); chk("wr_rdat", dRdat2, 16'hBEEF);

        // Byte write at odd address; rdat must keep the previous read.
        dirTxn(1'b1, 1'b1, 16'h0203, 16'h12A5);
        chk("bw_sel", sSel, 2'b10); chk("bw_dat", sDat, 16'hA5A5); chk("bw_we", sWe, 1);
        chk("bw_done", dDone2, 1); chk("bw_rdat", dRdat2, 16'hBEEF);

        // Byte reads, odd and even lanes.
        dirDat = 16'h7F80;
        dirTxn(1'b0, 1'b1, 16'h0011, 16'h0000);
        chk("br_odd_sel", sSel, 2'b10); chk("br_odd_rdat", dRdat2, 16'h007F);
        dirTxn(1'b0, 1'b1, 16'h0010, 16'h0000);
        chk("br_even_sel", sSel, 2'b01); chk("br_even_rdat", dRdat2, 16'h0080);

        // Misaligned word access: no bus cycle, immediate error completion.
        dirTxn(1'b0, 1'b0, 16'h0101, 16'h0000);
        chk("mis_stb", sStb, 0); chk("mis_done", dDone1, 1); chk("mis_bad", dBad1, 1);
        chk("mis_done_once", dDone2, 0);

        // Reset on the third wait cycle abandons the bus cycle.
        respMode = 2;
        memEn = 1'b1; memWr = 1'b1; byteOp = 1'b0; adr = 16'h0200; wdat = 16'hCAFE;
        @(negedge clk); chk("rr_stb", stb_o, 1);
        @(negedge clk);
        @(negedge clk); arst = 1'b1; memEn = 1'b0;
        @(negedge clk);
        chk("rr_cyc", cyc_o, 0); chk("rr_we", we_o, 0); chk("rr_sel", sel_o, 0);
        chk("rr_adr", adr_o, 0); chk("rr_dat", dat_o, 0); chk("rr_rdat", rdat_o, 0);
        chk("rr_busy", memBusy_o, 0); chk("rr_done", memDone_o, 0); chk("rr_bad", badMem_o, 0);
        arst = 1'b0;
        @(negedge clk);
        respMode = 1;
        dirTxn(1'b1, 1'b0, 16'h0300, 16'h5A5A);
        chk("rr_after_stb", sStb, 1); chk("rr_after_dat", sDat, 16'h5A5A);
        chk("rr_after_done", dDone2, 1); chk("rr_after_bad", dBad2, 0);

        // Stalled bus: timeout or indefinite wait depending on build.
        respMode = 2;
        memEn = 1'b1; memWr = 1'b0; byteOp = 1'b0; adr = 16'h0400;
        cnt = 0; gotDone = 1'b0; gotBad = 1'b0;
`ifdef XM_MEM_TIMEOUT_EN
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (memDone_o) begin gotDone = 1'b1; gotBad = badMem_o; break; end
            if (stb_o) cnt++;
        end
        chk("to_cycles", cnt, c_TIMEOUT); chk("to_done", gotDone, 1); chk("to_bad", gotBad, 1);
        memEn = 1'b0;
        @(negedge clk);
`else
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (stb_o) cnt++;
            if (memDone_o) gotDone = 1'b1;
        end
        chk("stall_stb", cnt, 120); chk("stall_done", gotDone, 0);
        arst = 1'b1; memEn = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
`endif

        // Random traffic with random ack timing and noise acks outside REQ.
        respMode = 0;
        for (int t = 0; t < 300; t++) rndTxn();

        repeat (3) @(negedge clk);
        chkEn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d errors=%0d", nVec, nErr);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/xm_mem_ctrl.md
XM_MEM_CTRL -- requirements
Module: xm_mem_ctrl

Interface
REQ-001 Parameter WORD, default 16: datapath and bus data/address width in bits.
REQ-002 Parameter TIMEOUT, default 15: maximum REQ-state cycles without ack_i; used only with XM_MEM_TIMEOUT_EN.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 arst_i  input  1  reset; synchronous, active-high.
REQ-005 memEn_i  input  1  memory request level from the control plane; held until memDone_o.
REQ-006 memWr_i  input  1  request type: 1 = write, 0 = read.
REQ-007 byteOp_i  input  1  byte access when 1; word access when 0.
REQ-008 adr_i  input  WORD  byte address of the access.
REQ-009 wdat_i  input  WORD  write data; byte writes use wdat_i[7:0].
REQ-010 rdat_o  output  WORD  registered read data; byte reads are zero-extended.
REQ-011 memBusy_o  output  1  high while a bus cycle is outstanding.
REQ-012 memDone_o  output  1  one-cycle completion pulse.
REQ-013 badMem_o  output  1  error flag, qualified by memDone_o.
REQ-014 ack_i  input  1  bus acknowledge.
REQ-015 dat_i  input  WORD  bus read data.
REQ-016 we_o, stb_o, cyc_o  output  1 each  bus write-enable, strobe and cycle signals.
REQ-017 sel_o  output  2  byte-lane select; bit 0 selects [7:0], bit 1 selects [15:8].
REQ-018 adr_o, dat_o  output  WORD  bus address and write data.

Function
REQ-019 The controller SHALL be an FSM with states IDLE, REQ and DONE, and all outputs SHALL be registered.
REQ-020 In IDLE with memEn_i=1, the next edge SHALL latch adr_i, wdat_i, memWr_i and byteOp_i.
REQ-021 On that accepting edge, an aligned or byte request SHALL enter REQ and drive cyc_o=stb_o=1 and we_o=memWr_i.
REQ-022 A word request with adr_i[0]=1 is misaligned: it SHALL raise no bus cycle, SHALL go IDLE->DONE, and SHALL assert badMem_o=1.
REQ-023 Word access: sel_o SHALL be 2'b11, dat_o SHALL be wdat_i, and adr_o SHALL be adr_i.
REQ-024 Byte access: sel_o SHALL be 2'b10 if adr_i[0]=1, else 2'b01; dat_o SHALL be {wdat_i[7:0], wdat_i[7:0]}; adr_o SHALL be adr_i.
REQ-025 memBusy_o SHALL equal 1 exactly while the FSM is in REQ.
REQ-026 In REQ with ack_i=1, the same edge SHALL deassert cyc_o/stb_o/we_o, clear sel_o, move to DONE, and, for reads, latch rdat_o.
REQ-027 Read data SHALL be latched as follows: word reads take dat_i; byte reads take {8'h00, dat_i[15:8]} if adr[0]=1, else {8'h00, dat_i[7:0]}.
REQ-028 Write completions SHALL leave rdat_o unchanged.
REQ-029 DONE SHALL last exactly one cycle, with memDone_o=1, and SHALL then return to IDLE; memEn_i SHALL be ignored in DONE.
REQ-030 Minimum latency SHALL be: accept edge N, ack_i sampled at edge N+1, memDone_o high during cycle N+1 to N+2.
REQ-031 ack_i SHALL be ignored outside REQ.
REQ-032 badMem_o SHALL be 0 on every successful completion.

Reset
REQ-033 arst_i=1 at an edge SHALL force IDLE from any state, including mid-REQ, so that the bus cycle is abandoned.
REQ-034 Reset SHALL clear cyc_o, stb_o, we_o, sel_o, adr_o, dat_o, rdat_o, memBusy_o, memDone_o, badMem_o and the timeout counter to 0.

Configuration
REQ-035 With XM_MEM_TIMEOUT_EN defined, a counter SHALL clear on REQ entry and increment each REQ cycle without ack_i.
REQ-036 With XM_MEM_TIMEOUT_EN defined, when the counter reaches TIMEOUT the controller SHALL deassert the bus signals, enter DONE and assert badMem_o=1.
REQ-037 With XM_MEM_TIMEOUT_EN defined and ack_i=1 on the terminal cycle, the ack SHALL win and the access SHALL complete normally.
REQ-038 Without XM_MEM_TIMEOUT_EN, no counter SHALL exist and REQ SHALL wait for ack_i indefinitely.

Verification
REQ-039 Word read: adr_i=16'h0100, memWr_i=0, byteOp_i=0, ack_i one cycle after stb_o with dat_i=16'hBEEF -> sel_o=2'b11, rdat_o=16'hBEEF, one memDone_o pulse, badMem_o=0.
REQ-040 Byte write at odd address: adr_i=16'h0203, wdat_i=16'h12A5 -> sel_o=2'b10, dat_o=16'hA5A5, we_o=1, memDone_o after ack_i.
REQ-041 Byte read at odd address: adr_i=16'h0011, dat_i=16'h7F80 -> rdat_o=16'h007F; the even-address case (16'h0010) -> rdat_o=16'h0080.
REQ-042 Misaligned word access: adr_i=16'h0101 -> cyc_o stays 0, memDone_o and badMem_o high one cycle after accept.
REQ-043 Reset mid-REQ: arst_i pulsed on the 3rd wait cycle -> cyc_o=0 next edge, all outputs 0, a subsequent request completes normally.
REQ-044 Timeout with XM_MEM_TIMEOUT_EN and TIMEOUT=15: ack_i held 0 -> bus released after 15 REQ cycles, badMem_o=1; without the macro, stb_o stays high for 100+ cycles.
